// File: rtl/alu_op_sequencer.sv
// ALU-control stage: decodes ALUOp/ALUSrc/instruction into an ALU selection code
// and sequences multi-cycle multiply/divide with stall, start/abort and done handshakes.
module alu_op_sequencer #(
  parameter int                 SEL_W      = 6,
  parameter logic [SEL_W-1:0]   MUL_CODE   = SEL_W'(6'h18),
  parameter logic [SEL_W-1:0]   DIV_CODE   = SEL_W'(6'h1A),
  parameter int                 MUL_CYCLES = 4,
  parameter int                 DIV_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic [1:0]       alu_op,
  input  logic             alu_src,
  input  logic [31:0]      instruction,
  input  logic             flush,
  output logic [SEL_W-1:0] selection,
  output logic             sel_valid,
  output logic             stall,
  output logic             mdu_start,
  output logic             mdu_div,
  output logic             mdu_abort,
  output logic             done,
  output logic             illegal
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [SEL_W-1:0] ADD_CODE = SEL_W'(6'h20);
  localparam logic [SEL_W-1:0] SUB_CODE = SEL_W'(6'h22);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] selection_q, selection_d;
  logic             sel_valid_q, sel_valid_d;
  logic             mdu_start_q, mdu_start_d;
  logic             mdu_div_q, mdu_div_d;
  logic             mdu_abort_q, mdu_abort_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;

  logic [SEL_W-1:0] funct, opcode, dec_sel;
  logic             is_illegal, is_multi, is_div;
  logic             unused_instr;

  always_comb begin
    funct        = instruction[SEL_W-1:0];
    opcode       = instruction[31:32-SEL_W];
    unused_instr = ^instruction;

    case (alu_op)
      2'b00:   dec_sel = ADD_CODE;
      2'b01:   dec_sel = SUB_CODE;
      2'b10:   dec_sel = alu_src ? opcode : funct;
      default: dec_sel = selection_q;
    endcase

    is_illegal = (alu_op == 2'b11);
    is_div     = (funct == DIV_CODE);
    is_multi   = (alu_op == 2'b10) && !alu_src && ((funct == MUL_CODE) || is_div);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    selection_d = selection_q;
    mdu_div_d   = mdu_div_q;
    sel_valid_d = 1'b0;
    mdu_start_d = 1'b0;
    mdu_abort_d = 1'b0;
    done_d      = 1'b0;
    illegal_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (issue && !flush) begin
          if (is_illegal) begin
            illegal_d = 1'b1;
          end else if (is_multi) begin
            selection_d = dec_sel;
            mdu_start_d = 1'b1;
            mdu_div_d   = is_div;
            cnt_d       = is_div ? DIV_LOAD : MUL_LOAD;
            state_d     = BUSY;
          end else begin
            selection_d = dec_sel;
            sel_valid_d = 1'b1;
          end
        end
      end
      BUSY: begin
        // flush outranks completion even on the final count
        if (flush) begin
          state_d     = IDLE;
          cnt_d       = '0;
          mdu_abort_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          sel_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      selection_q <= '0;
      sel_valid_q <= 1'b0;
      mdu_start_q <= 1'b0;
      mdu_div_q   <= 1'b0;
      mdu_abort_q <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      selection_q <= selection_d;
      sel_valid_q <= sel_valid_d;
      mdu_start_q <= mdu_start_d;
      mdu_div_q   <= mdu_div_d;
      mdu_abort_q <= mdu_abort_d;
      done_q      <= done_d;
      illegal_q   <= illegal_d;
    end
  end

  always_comb begin
    selection = selection_q;
    sel_valid = sel_valid_q;
    stall     = (state_q == BUSY);
    mdu_start = mdu_start_q;
    mdu_div   = mdu_div_q;
    mdu_abort = mdu_abort_q;
    done      = done_q;
    illegal   = illegal_q;
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: stimulus pushes expected pulse events,
// a negedge monitor pops and compares whenever the DUT raises any pulse output.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst, issue, alu_src, flush;
  logic [1:0]  alu_op;
  logic [31:0] instruction;
  logic [5:0]  selection;
  logic        sel_valid, stall, mdu_start, mdu_div, mdu_abort, done, illegal;

  int compared   = 0;
  int mismatched = 0;

  // flags order: sel_valid, done, mdu_start, mdu_div, mdu_abort, illegal, stall
  typedef struct {
    logic [6:0] flags;
    logic [5:0] sel;
    int         run;
  } exp_t;

  exp_t exp_q[$];
  int   run_cnt  = 0;
  int   last_run = 0;

  alu_op_sequencer #(
    .SEL_W(6), .MUL_CODE(6'h18), .DIV_CODE(6'h1A), .MUL_CYCLES(4), .DIV_CYCLES(32)
  ) dut (
    .clk(clk), .rst(rst), .issue(issue), .alu_op(alu_op), .alu_src(alu_src),
    .instruction(instruction), .flush(flush), .selection(selection),
    .sel_valid(sel_valid), .stall(stall), .mdu_start(mdu_start), .mdu_div(mdu_div),
    .mdu_abort(mdu_abort), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic sv, input logic dn, input logic st, input logic dv,
                      input logic ab, input logic il, input logic stl,
                      input logic [5:0] s, input int run);
    exp_t e;
    e.flags = {sv, dn, st, dv, ab, il, stl};
    e.sel   = s;
    e.run   = run;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] op, input logic src, input logic [31:0] ins);
    issue       = 1'b1;
    alu_op      = op;
    alu_src     = src;
    instruction = ins;
  endtask

  task automatic check_quiet(input string name);
    logic [13:0] act;
    act = {sel_valid, done, mdu_start, mdu_div, mdu_abort, illegal, stall, selection};
    compared++;
    if (act !== 14'h0) begin
      mismatched++;
      $display("FAIL %s: outputs=%h required=0000", name, act);
    end
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [6:0] act;
    if (stall) run_cnt++;
    else if (run_cnt > 0) begin
      last_run = run_cnt;
      run_cnt  = 0;
    end
    if (sel_valid | done | mdu_start | mdu_abort | illegal) begin
      act = {sel_valid, done, mdu_start, mdu_div, mdu_abort, illegal, stall};
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_event: flags=%b sel=%h with nothing expected", act, selection);
      end else begin
        e = exp_q.pop_front();
        if (act !== e.flags || selection !== e.sel || (e.run >= 0 && last_run != e.run)) begin
          mismatched++;
          $display("FAIL event: flags=%b sel=%h run=%0d required flags=%b sel=%h run=%0d",
                   act, selection, last_run, e.flags, e.sel, e.run);
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; issue = 1'b0; alu_op = 2'b00; alu_src = 1'b0;
    instruction = '0; flush = 1'b0;
    cyc; cyc;
    rst = 1'b0;
    check_quiet("reset_state");

    push(1, 0, 0, 0, 0, 0, 0, 6'h20, -1);
    drive(2'b00, 1'b0, 32'h1234_5678); cyc; issue = 1'b0;
    push(1, 0, 0, 0, 0, 0, 0, 6'h22, -1);
    drive(2'b01, 1'b0, 32'h0000_0000); cyc; issue = 1'b0;
    push(1, 0, 0, 0, 0, 0, 0, 6'h24, -1);
    drive(2'b10, 1'b0, 32'h0000_0024); cyc; issue = 1'b0;
    push(1, 0, 0, 0, 0, 0, 0, 6'h08, -1);
    drive(2'b10, 1'b1, 32'h2000_0000); cyc; issue = 1'b0;

    // multiply, then an ADD held through the stall and accepted on the done cycle
    push(0, 0, 1, 0, 0, 0, 1, 6'h18, -1);
    push(1, 1, 0, 0, 0, 0, 0, 6'h18, 4);
    push(1, 0, 0, 0, 0, 0, 0, 6'h20, -1);
    drive(2'b10, 1'b0, 32'h0000_0018); cyc;
    drive(2'b00, 1'b0, 32'h0000_0000);
    n = 0;
    while (stall && n < 100) begin cyc; n++; end
    if (n >= 100) begin
      compared++; mismatched++;
      $display("FAIL mul_stall_bound: stall=%b after %0d cycles required 0", stall, n);
    end
    cyc; issue = 1'b0;

    push(0, 0, 0, 0, 0, 1, 0, 6'h20, -1);
    drive(2'b11, 1'b0, 32'h0000_0018); cyc; issue = 1'b0;

    // divide killed at stall cycle 10
    push(0, 0, 1, 1, 0, 0, 1, 6'h1A, -1);
    push(0, 0, 0, 1, 1, 0, 0, 6'h1A, 10);
    drive(2'b10, 1'b0, 32'h0000_001A); cyc; issue = 1'b0;
    repeat (9) cyc;
    flush = 1'b1; cyc; flush = 1'b0;
    cyc;

    // divide killed on the final count
    push(0, 0, 1, 1, 0, 0, 1, 6'h1A, -1);
    push(0, 0, 0, 1, 1, 0, 0, 6'h1A, 32);
    drive(2'b10, 1'b0, 32'h0000_001A); cyc; issue = 1'b0;
    repeat (31) cyc;
    flush = 1'b1; cyc; flush = 1'b0;
    cyc;

    // flush in IDLE discards the concurrent issue
    flush = 1'b1; drive(2'b00, 1'b0, 32'h0); cyc; issue = 1'b0; flush = 1'b0;
    cyc; cyc;

    // reset in the middle of a divide
    push(0, 0, 1, 1, 0, 0, 1, 6'h1A, -1);
    drive(2'b10, 1'b0, 32'h0000_001A); cyc; issue = 1'b0;
    repeat (4) cyc;
    rst = 1'b1; cyc;
    check_quiet("reset_mid_divide");
    rst = 1'b0;
    push(1, 0, 0, 0, 0, 0, 0, 6'h20, -1);
    drive(2'b00, 1'b0, 32'h0); cyc; issue = 1'b0;
    repeat (3) cyc;

    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL missing_events: %0d pending required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
